regfile_writeback: RTL and testbench
====================================

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 The block SHALL use reset RESET, synchronous, active-high, and clock CLK.
REQ-002 The block SHALL have ports exactly as follows (name  direction  width  meaning):
 - CLK  in  1  rising-edge clock
 - RESET  in  1  synchronous active-high reset
 - PIPE_VALID  in  1  MEM/WB stage result valid; no backpressure
 - PIPE_ADDR  in  5  MEM/WB destination register
 - PIPE_DATA  in  32  MEM/WB result
 - MD_VALID  in  1  mul/div unit result valid
 - MD_ADDR  in  5  mul/div destination register
 - MD_DATA  in  32  mul/div result
 - MD_READY  out  1  result queue can accept a mul/div result
 - ISSUE_VALID  in  1  mul/div instruction issued this cycle
 - ISSUE_ADDR  in  5  destination of the issued mul/div instruction
 - RF_WRITE  out  1  register file write enable
 - RF_INADDRESS  out  5  register file write address
 - RF_IN  out  32  register file write data
 - BUSY_MASK  out  32  per-register pending mul/div result flags
 - STALL_REQ  out  1  MEM/WB producer must hold off
 - FIFO_COUNT  out  3  queued mul/div results, 0..4
 - ERROR  out  1  sticky protocol-violation flag

Function
REQ-003 An mul/div result SHALL be accepted on a rising edge where MD_VALID=1 and MD_READY=1; MD_READY SHALL be 1 iff the registered FIFO_COUNT<4.
REQ-004 An accepted result with MD_ADDR=0 SHALL be discarded and not enqueued; otherwise it SHALL be pushed into a 4-entry FIFO in arrival order.
REQ-005 Each cycle the arbiter SHALL select, in priority order: (a) PIPE_VALID=1 with PIPE_ADDR!=0; (b) the FIFO head if FIFO_COUNT>0; (c) no write.
REQ-006 PIPE_VALID=1 with PIPE_ADDR=0 SHALL not produce a write and SHALL NOT block the FIFO from draining that cycle.
REQ-007 RF_WRITE, RF_INADDRESS and RF_IN SHALL be registered: the selected write appears on the outputs one cycle after selection, with RF_WRITE=0 and the address/data holding their previous values when nothing is selected.
REQ-008 Latency SHALL be 1 cycle from PIPE_VALID to RF_WRITE, and at least 2 cycles from MD acceptance to RF_WRITE (no FIFO bypass).
REQ-009 A push and a pop in the same cycle SHALL leave FIFO_COUNT unchanged; a pop SHALL only occur when FIFO_COUNT>0.
REQ-010 STALL_REQ SHALL be 1 iff FIFO_COUNT=4; the MEM/WB producer then holds PIPE_VALID=0, guaranteeing a drain.
REQ-011 ISSUE_VALID=1 with ISSUE_ADDR!=0 SHALL set BUSY_MASK[ISSUE_ADDR] on the next edge; ISSUE_ADDR=0 SHALL be ignored.
REQ-012 A FIFO pop SHALL clear BUSY_MASK[head address] on the same edge that registers the write.
REQ-013 When a set and a clear target the same bit in one cycle, the set SHALL win.
REQ-014 ERROR SHALL be set and held when ISSUE_VALID=1 targets a register whose BUSY_MASK bit is already 1, or when MD_VALID=1 while MD_READY=0; the cleared/set bit behaviour is otherwise unchanged.
REQ-015 BUSY_MASK[0] SHALL always read 0.

Reset
REQ-016 On RESET=1 at a rising edge, the FIFO SHALL be emptied (FIFO_COUNT=0), and BUSY_MASK, RF_WRITE, RF_INADDRESS, RF_IN, STALL_REQ and ERROR SHALL become 0; MD_READY SHALL then read 1.
REQ-017 RESET SHALL take priority over all simultaneous pushes, pops, issues and pipe writes; queued results in flight SHALL be discarded without writing.

Structure
REQ-018 A shared package SHALL hold XLEN=32, REG_ADDR_W=5, NUM_REGS=32, WB_FIFO_DEPTH=4 and the FIFO entry record (address, data).
REQ-019 The FIFO SHALL be a separate sub-module, wb_fifo, with push/pop/count/head ports and synchronous reset; the arbiter, output registers and scoreboard live in regfile_writeback.

Verification
REQ-020 The bench SHALL cover:
 - PIPE_VALID=1, PIPE_ADDR=5, PIPE_DATA=0xDEADBEEF for one cycle -> RF_WRITE=1, RF_INADDRESS=5, RF_IN=0xDEADBEEF one cycle later, for exactly one cycle.
 - ISSUE x7; MD result x7=0x12345678 with PIPE idle -> BUSY_MASK[7]=1, then RF_WRITE x7 2 cycles after acceptance, and BUSY_MASK[7]=0 on that edge.
 - 4 MD results to x1..x4 while PIPE_VALID stays high to x9 -> FIFO_COUNT=4, MD_READY=0, STALL_REQ=1; after PIPE drops, x1..x4 are written in order on 4 consecutive cycles.
 - PIPE_ADDR=0 with FIFO holding x3 -> no x0 write; x3 is written that cycle's next edge.
 - ISSUE x8 twice without result -> ERROR=1 and held; RESET -> ERROR=0.
 - RESET asserted with FIFO_COUNT=3 and BUSY_MASK=0x0000001C -> next cycle FIFO_COUNT=0, BUSY_MASK=0, no RF_WRITE of queued entries.

Source files
------------

// File: rtl/regfile_writeback_pkg.sv
// regfile_writeback_pkg: shared widths, depths and the queued write-back record
package regfile_writeback_pkg;
  localparam int XLEN          = 32;
  localparam int REG_ADDR_W    = 5;
  localparam int NUM_REGS      = 32;
  localparam int WB_FIFO_DEPTH = 4;
  localparam int CNT_W         = $clog2(WB_FIFO_DEPTH + 1);
  localparam int PTR_W         = $clog2(WB_FIFO_DEPTH);
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_fifo.sv
// wb_fifo: small in-order queue of mul/div results awaiting a free write port
module wb_fifo
  import regfile_writeback_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  i_push,
  input  logic [REG_ADDR_W-1:0] i_push_addr,
  input  logic [XLEN-1:0]       i_push_data,
  input  logic                  i_pop,
  output logic [REG_ADDR_W-1:0] o_head_addr,
  output logic [XLEN-1:0]       o_head_data,
  output logic [CNT_W-1:0]      o_count
);
  wb_entry_t        r_mem [WB_FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_count;
  // Storage needs no reset: the count alone decides which entries are live
  always_ff @(posedge CLK)
    if (i_push) r_mem[r_wr] <= '{addr: i_push_addr, data: i_push_data};
  // Pointers and occupancy; callers never push when full or pop when empty
  always_ff @(posedge CLK)
    if (RESET) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= r_wr + PTR_W'(i_push);
      r_rd    <= r_rd + PTR_W'(i_pop);
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  assign o_head_addr = r_mem[r_rd].addr;
  assign o_head_data = r_mem[r_rd].data;
  assign o_count     = r_count;
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges MEM/WB and queued mul/div results onto one register-file write port
module regfile_writeback
  import regfile_writeback_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  PIPE_VALID,
  input  logic [REG_ADDR_W-1:0] PIPE_ADDR,
  input  logic [XLEN-1:0]       PIPE_DATA,
  input  logic                  MD_VALID,
  input  logic [REG_ADDR_W-1:0] MD_ADDR,
  input  logic [XLEN-1:0]       MD_DATA,
  output logic                  MD_READY,
  input  logic                  ISSUE_VALID,
  input  logic [REG_ADDR_W-1:0] ISSUE_ADDR,
  output logic                  RF_WRITE,
  output logic [REG_ADDR_W-1:0] RF_INADDRESS,
  output logic [XLEN-1:0]       RF_IN,
  output logic [NUM_REGS-1:0]   BUSY_MASK,
  output logic                  STALL_REQ,
  output logic [CNT_W-1:0]      FIFO_COUNT,
  output logic                  ERROR
);
  logic                  w_push;
  logic                  w_pop;
  logic                  w_pipe_sel;
  logic                  w_issue;
  logic                  w_err;
  logic [REG_ADDR_W-1:0] w_head_addr;
  logic [XLEN-1:0]       w_head_data;
  logic [NUM_REGS-1:0]   w_busy_next;

  wb_fifo u_fifo (
    .CLK         (CLK),
    .RESET       (RESET),
    .i_push      (w_push),
    .i_push_addr (MD_ADDR),
    .i_push_data (MD_DATA),
    .i_pop       (w_pop),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_count     (FIFO_COUNT)
  );

  assign MD_READY   = FIFO_COUNT < CNT_W'(WB_FIFO_DEPTH);
  assign STALL_REQ  = FIFO_COUNT == CNT_W'(WB_FIFO_DEPTH);
  assign w_push     = MD_VALID && MD_READY && MD_ADDR != '0;
  assign w_pipe_sel = PIPE_VALID && PIPE_ADDR != '0;
  assign w_pop      = !w_pipe_sel && FIFO_COUNT != '0;
  assign w_issue    = ISSUE_VALID && ISSUE_ADDR != '0;
  assign w_err      = (w_issue && BUSY_MASK[ISSUE_ADDR]) || (MD_VALID && !MD_READY);

  // Pending-result scoreboard: pop clears first so a same-cycle issue wins; x0 never pends
  always_comb begin
    w_busy_next = BUSY_MASK;
    if (w_pop) w_busy_next[w_head_addr] = 1'b0;
    if (w_issue) w_busy_next[ISSUE_ADDR] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  // Registered write port: pipe beats queue; address/data hold when idle
  always_ff @(posedge CLK)
    if (RESET) begin
      RF_WRITE     <= 1'b0;
      RF_INADDRESS <= '0;
      RF_IN        <= '0;
    end else begin
      RF_WRITE <= w_pipe_sel || w_pop;
      if (w_pipe_sel || w_pop) begin
        RF_INADDRESS <= w_pipe_sel ? PIPE_ADDR : w_head_addr;
        RF_IN        <= w_pipe_sel ? PIPE_DATA : w_head_data;
      end
    end

  // Scoreboard and sticky protocol-error flag
  always_ff @(posedge CLK)
    if (RESET) begin
      BUSY_MASK <= '0;
      ERROR     <= 1'b0;
    end else begin
      BUSY_MASK <= w_busy_next;
      ERROR     <= ERROR || w_err;
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed-vector self-checking bench for regfile_writeback
module tb_regfile_writeback;
  logic        CLK = 1'b0;
  logic        RESET;
  logic        PIPE_VALID;
  logic [4:0]  PIPE_ADDR;
  logic [31:0] PIPE_DATA;
  logic        MD_VALID;
  logic [4:0]  MD_ADDR;
  logic [31:0] MD_DATA;
  logic        MD_READY;
  logic        ISSUE_VALID;
  logic [4:0]  ISSUE_ADDR;
  logic        RF_WRITE;
  logic [4:0]  RF_INADDRESS;
  logic [31:0] RF_IN;
  logic [31:0] BUSY_MASK;
  logic        STALL_REQ;
  logic [2:0]  FIFO_COUNT;
  logic        ERROR;
  int          n_total = 0;
  int          n_pass  = 0;

  regfile_writeback dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PIPE_VALID   (PIPE_VALID),
    .PIPE_ADDR    (PIPE_ADDR),
    .PIPE_DATA    (PIPE_DATA),
    .MD_VALID     (MD_VALID),
    .MD_ADDR      (MD_ADDR),
    .MD_DATA      (MD_DATA),
    .MD_READY     (MD_READY),
    .ISSUE_VALID  (ISSUE_VALID),
    .ISSUE_ADDR   (ISSUE_ADDR),
    .RF_WRITE     (RF_WRITE),
    .RF_INADDRESS (RF_INADDRESS),
    .RF_IN        (RF_IN),
    .BUSY_MASK    (BUSY_MASK),
    .STALL_REQ    (STALL_REQ),
    .FIFO_COUNT   (FIFO_COUNT),
    .ERROR        (ERROR)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".we"}, 32'(RF_WRITE), 32'(we));
    chk({tag, ".addr"}, 32'(RF_INADDRESS), 32'(a));
    chk({tag, ".data"}, RF_IN, d);
  endtask

  task automatic idle();
    PIPE_VALID = 0; PIPE_ADDR = 0; PIPE_DATA = 0;
    MD_VALID = 0; MD_ADDR = 0; MD_DATA = 0;
    ISSUE_VALID = 0; ISSUE_ADDR = 0;
  endtask

  initial begin
    idle();
    RESET = 1;
    step(); step();
    RESET = 0;
    wr("reset", 0, 0, 0);
    chk("reset.count", 32'(FIFO_COUNT), 0);
    chk("reset.busy", BUSY_MASK, 0);
    chk("reset.ready", 32'(MD_READY), 1);
    chk("reset.stall", 32'(STALL_REQ), 0);
    chk("reset.error", 32'(ERROR), 0);

    PIPE_VALID = 1; PIPE_ADDR = 5; PIPE_DATA = 32'hDEADBEEF;
    step(); idle();
    wr("pipe.x5", 1, 5, 32'hDEADBEEF);
    step();
    wr("pipe.x5.after", 0, 5, 32'hDEADBEEF);

    ISSUE_VALID = 1; ISSUE_ADDR = 7;
    step(); idle();
    chk("issue.x7.busy", BUSY_MASK, 32'h80);
    MD_VALID = 1; MD_ADDR = 7; MD_DATA = 32'h12345678;
    step(); idle();
    chk("md.x7.count", 32'(FIFO_COUNT), 1);
    chk("md.x7.nowrite", 32'(RF_WRITE), 0);
    chk("md.x7.busy_held", BUSY_MASK, 32'h80);
    step();
    wr("md.x7", 1, 7, 32'h12345678);
    chk("md.x7.busy_clr", BUSY_MASK, 0);
    chk("md.x7.count0", 32'(FIFO_COUNT), 0);
    step();
    chk("md.x7.after", 32'(RF_WRITE), 0);

    PIPE_VALID = 1; PIPE_ADDR = 9; PIPE_DATA = 32'h99;
    for (int i = 1; i <= 4; i++) begin
      MD_VALID = 1; MD_ADDR = 5'(i); MD_DATA = 32'h11 * i;
      step();
      wr("fill.pipe.x9", 1, 9, 32'h99);
    end
    idle();
    chk("fill.count", 32'(FIFO_COUNT), 4);
    chk("fill.ready", 32'(MD_READY), 0);
    chk("fill.stall", 32'(STALL_REQ), 1);
    chk("fill.error", 32'(ERROR), 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      wr("drain", 1, 5'(i), 32'h11 * i);
      chk("drain.count", 32'(FIFO_COUNT), 32'(4 - i));
    end
    step();
    chk("drain.done", 32'(RF_WRITE), 0);
    chk("drain.stall", 32'(STALL_REQ), 0);

    MD_VALID = 1; MD_ADDR = 3; MD_DATA = 32'h33;
    step(); idle();
    chk("x3.count", 32'(FIFO_COUNT), 1);
    PIPE_VALID = 1; PIPE_ADDR = 0; PIPE_DATA = 32'hBAD;
    step(); idle();
    wr("pipe0.x3", 1, 3, 32'h33);
    chk("pipe0.count", 32'(FIFO_COUNT), 0);
    MD_VALID = 1; MD_ADDR = 0; MD_DATA = 32'h5A5A;
    step(); idle();
    chk("md0.discard", 32'(FIFO_COUNT), 0);
    step();
    wr("md0.nowrite", 0, 3, 32'h33);

    ISSUE_VALID = 1; ISSUE_ADDR = 8;
    step();
    chk("x8.busy", BUSY_MASK, 32'h100);
    chk("x8.once", 32'(ERROR), 0);
    step(); idle();
    chk("x8.twice", 32'(ERROR), 1);
    step();
    chk("x8.held", 32'(ERROR), 1);
    chk("x8.busy_held", BUSY_MASK, 32'h100);
    RESET = 1;
    step();
    RESET = 0;
    chk("x8.rst.error", 32'(ERROR), 0);
    chk("x8.rst.busy", BUSY_MASK, 0);

    PIPE_VALID = 1; PIPE_ADDR = 10; PIPE_DATA = 32'hA0;
    for (int i = 0; i < 3; i++) begin
      ISSUE_VALID = 1; ISSUE_ADDR = 5'(2 + i);
      MD_VALID = 1; MD_ADDR = 5'(20 + i); MD_DATA = 32'h200 + i;
      step();
    end
    chk("pre.count", 32'(FIFO_COUNT), 3);
    chk("pre.busy", BUSY_MASK, 32'h1C);
    ISSUE_ADDR = 5; MD_ADDR = 23;
    RESET = 1;
    step();
    RESET = 0; idle();
    chk("rst.count", 32'(FIFO_COUNT), 0);
    chk("rst.busy", BUSY_MASK, 0);
    wr("rst.port", 0, 0, 0);
    chk("rst.ready", 32'(MD_READY), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst.nowrite", 32'(RF_WRITE), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
